// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared constants, read tag type and pointer helper for mem_arbiter.
package mem_arb_pkg;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } rd_tag_t;

    // With skip0 the pointer wraps to 1, leaving requester 0 out of the rotation.
    function automatic int rr_next(input int w, input int n, input bit skip0);
        return (w + 1 >= n) ? (skip0 ? 1 : 0) : w + 1;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx
);
    localparam int W = $clog2(N);

    // Scan from farthest to nearest so the nearest requester overwrites the others.
    always_comb begin
        gnt = '0;
        gnt_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N]) begin
                gnt = '0;
                gnt[(int'(ptr) + i) % N] = 1'b1;
                gnt_idx = W'((int'(ptr) + i) % N);
            end
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory among NUM_REQ requesters, in-order read return.
// Define MEM_ARB_FIXED_PRIO_EN to make requester 0 win whenever it is valid.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MEM_RD_LAT = 1
) (
    input  logic                      clk_i,
    input  logic                      arst_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [NUM_REQ-1:0]        req_we_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]        rsp_valid_o,
    output logic [DATA_W-1:0]         rsp_rdata_o,
    output logic                      mem_srst_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    output logic                      mem_we_o,
    output logic [DATA_W-1:0]         mem_wdata_o,
    input  logic [DATA_W-1:0]         mem_rdata_i
);
    localparam int PW = $clog2(NUM_REQ);
`ifdef MEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic [PW-1:0]      ptr_q, ptr_d, arb_idx, win;
    logic [NUM_REQ-1:0] arb_req, arb_gnt, gnt;
    logic               fire, srst_q, we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    rd_tag_t            tag_q [MEM_RD_LAT+1];
    rd_tag_t            tag_d [MEM_RD_LAT+1];

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req     (arb_req),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    always_comb begin
        arb_req = FIXED ? (req_valid_i & ~NUM_REQ'(1)) : req_valid_i;
        gnt = (FIXED && req_valid_i[0]) ? NUM_REQ'(1) : arb_gnt;
        win = (FIXED && req_valid_i[0]) ? '0 : arb_idx;
        req_ready_o = srst_q ? '0 : gnt;
        fire = |req_ready_o;
        ptr_d = (fire && !(FIXED && win == '0)) ? PW'(rr_next(int'(win), NUM_REQ, FIXED)) : ptr_q;
        addr_d = fire ? req_addr_i[win*ADDR_W +: ADDR_W] : addr_q;
        wdata_d = fire ? req_wdata_i[win*DATA_W +: DATA_W] : wdata_q;
        we_d = fire & req_we_i[win];
        tag_d[0].valid = fire & ~req_we_i[win];
        tag_d[0].idx = 3'(win);
        for (int i = 1; i <= MEM_RD_LAT; i++) tag_d[i] = tag_q[i-1];
        rsp_valid_o = tag_q[MEM_RD_LAT].valid ? (NUM_REQ'(1) << tag_q[MEM_RD_LAT].idx) : '0;
        rsp_rdata_o = tag_q[MEM_RD_LAT].valid ? mem_rdata_i : '0;
    end

    // srst_q doubles as the memory reset stretch and the post-reset grant block.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            ptr_q <= '0;
            srst_q <= 1'b1;
            we_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            tag_q <= '{default: '0};
        end else begin
            ptr_q <= ptr_d;
            srst_q <= 1'b0;
            we_q <= we_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            tag_q <= tag_d;
        end
    end

    assign mem_srst_o = srst_q;
    assign mem_addr_o = addr_q;
    assign mem_we_o = we_q;
    assign mem_wdata_o = wdata_q;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-port `memory` block among NUM_REQ requesters with a fully pipelined valid/ready front end. Up to one access per cycle is granted. The granted command is registered onto the memory port. Read data is routed back to the originating requester in issue order. The block sits between the requesting engines and the `memory` instance, and drives all of that instance's inputs except the clock.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- ADDR_W, 8: memory address width.
- DATA_W, 32: memory data width.
- MEM_RD_LAT, 1: cycles from the memory sampling `addr` to `rdata` being valid.

Ports:
- clk_i  in  1  single clock; all logic on its rising edge.
- arst_i  in  1  reset, asynchronous, active-high.
- req_valid_i  in  NUM_REQ  request valid, one bit per requester.
- req_ready_o  out  NUM_REQ  grant/accept, one-hot or zero.
- req_we_i  in  NUM_REQ  1 = write, 0 = read.
- req_addr_i  in  NUM_REQ*ADDR_W  packed addresses; requester k occupies slice k.
- req_wdata_i  in  NUM_REQ*DATA_W  packed write data.
- rsp_valid_o  out  NUM_REQ  read data valid, one-hot or zero.
- rsp_rdata_o  out  DATA_W  read data, shared by all requesters.
- mem_srst_o  out  1  to memory `srst_i`.
- mem_addr_o  out  ADDR_W  to memory `addr_i`.
- mem_we_o  out  1  to memory `we_i`.
- mem_wdata_o  out  DATA_W  to memory `wdata_i`.
- mem_rdata_i  in  DATA_W  from memory `rdata_o`.

## Operation
- **Grant.** `req_ready_o` is combinational from `req_valid_i` and the priority pointer.
  - Exactly one valid requester is granted per cycle.
  - `req_ready_o[k]` never depends on `req_ready_o` feedback.
  - A handshake occurs when `valid[k] & ready[k]`.
- **Round robin.** The pointer `ptr` (reset 0) marks the highest-priority requester.
  - The winner is the first valid requester at or after `ptr`, searching modulo NUM_REQ.
  - After granting requester w, `ptr <= (w+1) % NUM_REQ`.
  - `ptr` holds when nothing is granted.
- **Issue.**
  - On a handshake, `mem_addr_o`, `mem_we_o` and `mem_wdata_o` are registered from the winner's slices.
  - With no handshake, `mem_we_o` is 0 and address/data hold their last value.
- **Writes.** Fire-and-forget; no response.
- **Reads.**
  - A tag (valid + requester index) enters a shift register of depth MEM_RD_LAT+1.
  - At the tail of the shift register, `rsp_valid_o[idx]` pulses for 1 cycle, with `rsp_rdata_o` equal to `mem_rdata_i` of that cycle.
  - Responses are in issue order and cannot be stalled; requesters must always accept them.
- **Ordering.** All accesses go through one in-order pipe. A read issued after a write to the same address returns the new data.
- **Memory reset.** `mem_srst_o` is 1 while `arst_i` is asserted and for 1 cycle after its release, then 0.
- **Reset mid-operation.** In-flight tags are discarded, no response is produced, and `ptr` returns to 0.
- **Requester behaviour.** A requester may drop `valid` without a handshake; this is not an error.

## Timing
- **Reset values:**
  - `req_ready_o`: combinational, 0 while in reset.
  - `rsp_valid_o` = 0.
  - `rsp_rdata_o` = 0.
  - `mem_addr_o` = 0.
  - `mem_we_o` = 0.
  - `mem_wdata_o` = 0.
  - `mem_srst_o` = 1.
- **Read latency** with handshake in cycle N:
  - `mem_*` are valid in cycle N+1.
  - `rsp_valid_o` is asserted in cycle N+1+MEM_RD_LAT (N+2 at the default).
- **Throughput.** One handshake per cycle sustained, with mixed reads and writes back to back.
- **During the `mem_srst_o` cycle.** `req_ready_o` is all 0.
- **Back-to-back grants.** With all requesters valid continuously, grants rotate 0,1,2,3,0,…

## Configuration
- `MEM_ARB_FIXED_PRIO_EN` defined:
  - Requester 0 is high priority and wins whenever valid.
  - `ptr` then rotates only over requesters 1..NUM_REQ-1, and grants to 0 leave `ptr` unchanged.
- Not defined: plain round robin over all requesters, as described above.

## Structure
- **Package `mem_arb_pkg`:**
  - Default ADDR_W/DATA_W constants.
  - `rd_tag_t` struct: valid, idx of `$clog2(NUM_REQ)` bits, widened to 3 bits fixed.
  - A `rr_next` function computing the next pointer.
- **Sub-module `rr_arbiter`:**
  - Parameter N; inputs `req`, `ptr`.
  - Outputs one-hot `gnt` and `gnt_idx`.
  - Purely combinational.
- `mem_arbiter` owns `ptr`, the issue register, the tag pipe and the reset stretch.

## Test plan
- **Reset.** Assert `arst_i` for 3 cycles mid-read. Required:
  - All outputs take their reset values immediately.
  - No `rsp_valid_o` after release.
  - `mem_srst_o` is 1 for exactly 1 cycle after release.
- **Single requester.** Requester 2 writes 0xDEADBEEF to address 0x10, then reads 0x10 on the next cycle. Required: `rsp_valid_o` = 4'b0100 two cycles after the read handshake, with `rsp_rdata_o` = 0xDEADBEEF.
- **Fairness.** All 4 requesters hold valid reads for 8 cycles. Required:
  - Grant order 0,1,2,3,0,1,2,3.
  - Eight responses in the same order, each with that requester's stored data.
- **Pipelining.** Requester 0 issues reads of 0x00..0x07 back to back. Required: `rsp_valid_o[0]` is high for 8 consecutive cycles with data in address order.
- **Priority, `MEM_ARB_FIXED_PRIO_EN` defined.** Requesters 0, 1 and 3 valid; requester 0 drops valid after 3 grants. Required: grants 0,0,0, then 1,3,1,3.
- **Withdrawal.** Requester 1 raises valid for 1 cycle while requester 0 is granted, then drops it. Required: no access is issued for requester 1, and `ptr` advances only past 0.
